// File: rtl/cast_credit_sender_pkg.sv
// Shared sizing for the cast network plus small types used by the credit sender.
// The macros are the codebase-wide link parameters that PE and sender both see.
`ifndef BUFFER_ALLOC
`define BUFFER_ALLOC 4
`endif
`ifndef BUFFER_ALLOC_LOG
`define BUFFER_ALLOC_LOG 2
`endif
`ifndef DW
`define DW 16
`endif
`ifndef CREDIT_W
`define CREDIT_W (`BUFFER_ALLOC_LOG+1)
`endif

package cast_credit_sender_pkg;

  localparam int DW         = `DW;
  localparam int SKID_DEPTH = 2;

  typedef logic [DW-1:0] flit_t;
  typedef logic [1:0]    occ_t;

  // Which transfers happen on the current edge; drives the occupancy update.
  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_IN   = 2'b01,
    XFER_OUT  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic xfer_e xfer_kind(input logic in_fire, input logic out_fire);
    return xfer_e'({out_fire, in_fire});
  endfunction

endpackage

// File: rtl/cast_credit_sender_credit_counter.sv
// Credit counter: one credit spent per flit sent, one returned per update pulse.
// Saturates at INIT; a return that would exceed INIT is flagged via overflow.
module credit_counter #(
  parameter int INIT = 4,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] INIT_V = W'(INIT);

  // A return with no matching spend while already full is a protocol error.
  assign overflow = inc & ~dec & (count == INIT_V);

  // Count update; a spend and a return on the same edge cancel out.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INIT_V;
    end else if (inc && !dec && !overflow) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cast_credit_sender.sv
// Credit-based injection stage for one cast-network link: a 2-entry skid buffer
// whose head flit is forwarded only while credit for the downstream FIFO remains.
module cast_credit_sender
  import cast_credit_sender_pkg::*;
#(
  parameter int CREDIT_INIT = `BUFFER_ALLOC,
  parameter int CW          = `CREDIT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  input  logic          credit_upd_i,
  output logic [CW-1:0] credits_o,
  output logic          err_o
);

  flit_t mem [SKID_DEPTH];
  logic  head;
  logic  tail;
  occ_t  occ;
  logic  in_fire;
  logic  out_fire;
  logic  overflow;
  logic  stall_err;

  assign ready_o  = (occ != 2'd2);
  assign valid_o  = (occ != 2'd0) && (credits_o != '0);
  assign data_o   = mem[head];
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Downstream refusing a flit while we hold every credit means its FIFO lies about being full.
  assign stall_err = valid_o & ~ready_i & (credits_o == CW'(CREDIT_INIT));

  credit_counter #(
    .INIT (CREDIT_INIT),
    .W    (CW)
  ) u_credit_counter (
    .clk      (clk),
    .rst      (rst),
    .dec      (out_fire),
    .inc      (credit_upd_i),
    .count    (credits_o),
    .overflow (overflow)
  );

  // Skid storage: accepted flits written at tail, head advances on each send.
  // NOTE: the two entries are reset because data_o shows the head entry and must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (in_fire) begin
        mem[tail] <= data_i;
        tail      <= ~tail;
      end
      if (out_fire) head <= ~head;
    end
  end

  // Occupancy: simultaneous accept and send leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
    end else begin
      case (xfer_kind(in_fire, out_fire))
        XFER_IN:  occ <= occ + 2'd1;
        XFER_OUT: occ <= occ - 2'd1;
        default:  occ <= occ;
      endcase
    end
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (overflow || stall_err) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cast_credit_sender.sv
// Self-checking bench for cast_credit_sender with BUFFER_ALLOC=4, DW=16.
module tb_cast_credit_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [15:0] data_o;
  logic        ready_i = 1'b0;
  logic        credit_upd_i = 1'b0;
  logic [2:0]  credits_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb [$];

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        c;
    logic        e_rdy;
    logic        e_vld;
    logic [2:0]  e_cred;
    logic        e_err;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  cast_credit_sender #(
    .CREDIT_INIT (4),
    .CW          (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .credit_upd_i (credit_upd_i),
    .credits_o    (credits_o),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare mid-cycle outputs, track flits in the scoreboard.
  task automatic cycle(input vec_t t);
    logic [15:0] exp_d;
    valid_i      = t.v;
    data_i       = t.d;
    ready_i      = t.r;
    credit_upd_i = t.c;
    @(negedge clk);
    check("ready_o", 32'(ready_o), 32'(t.e_rdy));
    check("valid_o", 32'(valid_o), 32'(t.e_vld));
    check("credits_o", 32'(credits_o), 32'(t.e_cred));
    check("err_o", 32'(err_o), 32'(t.e_err));
    if (t.e_vld && t.r) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_d = sb.pop_front();
        check("data_o", 32'(data_o), 32'(exp_d));
      end
    end
    if (t.v && t.e_rdy) sb.push_back(t.d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (tbl[i]) cycle(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    credit_upd_i = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state, sampled before any stimulus.
    @(negedge clk);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_credits_o", 32'(credits_o), 32'd4);
    check("rst_err_o", 32'(err_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    @(posedge clk);
    #1;

    //                v  d        r  c   rdy vld cred err
    // 1: six back-to-back flits, no credit returns.
    tbl.push_back('{1, 16'h0001, 1, 0,  1,  0,  4,  0});
    tbl.push_back('{1, 16'h0002, 1, 0,  1,  1,  4,  0});
    tbl.push_back('{1, 16'h0003, 1, 0,  1,  1,  3,  0});
    tbl.push_back('{1, 16'h0004, 1, 0,  1,  1,  2,  0});
    tbl.push_back('{1, 16'h0005, 1, 0,  1,  1,  1,  0});
    tbl.push_back('{1, 16'h0006, 1, 0,  1,  0,  0,  0});
    tbl.push_back('{0, 16'h0000, 1, 0,  0,  0,  0,  0});
    // 2: one credit return releases flit 5.
    tbl.push_back('{0, 16'h0000, 1, 1,  0,  0,  0,  0});
    tbl.push_back('{0, 16'h0000, 1, 0,  0,  1,  1,  0});
    // 3: build credits to 2, then send with a simultaneous return.
    tbl.push_back('{0, 16'h0000, 0, 1,  1,  0,  0,  0});
    tbl.push_back('{1, 16'h0007, 0, 1,  1,  1,  1,  0});
    tbl.push_back('{0, 16'h0000, 1, 1,  0,  1,  2,  0});
    tbl.push_back('{0, 16'h0000, 1, 1,  1,  1,  2,  0});
    // 4: refill to 4, then an extra return overflows; err stays set.
    tbl.push_back('{0, 16'h0000, 0, 1,  1,  0,  2,  0});
    tbl.push_back('{0, 16'h0000, 0, 1,  1,  0,  3,  0});
    tbl.push_back('{0, 16'h0000, 0, 1,  1,  0,  4,  0});
    tbl.push_back('{0, 16'h0000, 0, 0,  1,  0,  4,  1});
    tbl.push_back('{1, 16'h0008, 1, 0,  1,  0,  4,  1});
    tbl.push_back('{0, 16'h0000, 1, 0,  1,  1,  4,  1});
    tbl.push_back('{0, 16'h0000, 0, 0,  1,  0,  3,  1});
    run_table();

    // err clears only on reset.
    do_reset();

    // 5: three flits with ready_i toggling 1010; order preserved, credits end at 1.
    cycle('{1, 16'h00a1, 0, 0,  1,  0,  4,  0});
    cycle('{1, 16'h00a2, 1, 0,  1,  1,  4,  0});
    cycle('{1, 16'h00a3, 0, 0,  1,  1,  3,  0});
    cycle('{0, 16'h0000, 1, 0,  0,  1,  3,  0});
    cycle('{0, 16'h0000, 0, 0,  1,  1,  2,  0});
    cycle('{0, 16'h0000, 1, 0,  1,  1,  2,  0});
    cycle('{0, 16'h0000, 0, 0,  1,  0,  1,  0});
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: fill to occ=2 with one credit, then assert reset asynchronously mid-cycle.
    cycle('{1, 16'h00b1, 0, 0,  1,  0,  1,  0});
    cycle('{1, 16'h00b2, 0, 0,  1,  1,  1,  0});
    cycle('{0, 16'h0000, 0, 0,  0,  1,  1,  0});
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_o", 32'(valid_o), 32'd0);
    check("arst_ready_o", 32'(ready_o), 32'd1);
    check("arst_credits_o", 32'(credits_o), 32'd4);
    check("arst_err_o", 32'(err_o), 32'd0);
    check("arst_data_o", 32'(data_o), 32'd0);
    do_reset();

    // Stall error: downstream refuses a flit while every credit is held.
    cycle('{1, 16'h00c1, 0, 0,  1,  0,  4,  0});
    cycle('{0, 16'h0000, 0, 0,  1,  1,  4,  0});
    cycle('{0, 16'h0000, 1, 0,  1,  1,  4,  1});
    cycle('{0, 16'h0000, 0, 0,  1,  0,  3,  1});
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
